dspace_com_master: RTL and testbench

//  Master end of the FPGA-to-FPGA link: drives start pulse, bit-sync strobe and serial data
//  to the slave board, while shifting in the slave's serial reply. Sits between the master's

---
 rtl/dspace_com_master_pkg.sv | 18 +
 rtl/dspace_com_master_fpga_bit_timer.sv | 60 ++++++
 rtl/dspace_com_master.sv | 121 ++++++++++++
 tb/tb_dspace_com_master.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dspace_com_master_pkg.sv
// Shared constants and FSM state encoding for the master end of the board-to-board link.
package dspace_com_master_pkg;

    localparam int WORD_W     = 4;
    localparam int N_WORDS    = 3;
    localparam int FRAME_BITS = WORD_W * N_WORDS;
    localparam int MIN_PERIOD = 2;
    localparam int PERIOD_W   = 8;
    localparam int IDX_W      = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dspace_com_master_fpga_bit_timer.sv
// Bit-period timer: holds the latched period, the position inside the current bit and the
// index of the bit being sent, and decodes the sync, mid-bit sample and end-of-bit strobes.
module dspace_com_master_fpga_bit_timer
    import dspace_com_master_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period_in,
    output logic                sync_stb,
    output logic                sample_stb,
    output logic                wrap_stb,
    output logic                last_bit
);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                at_end;

    assign at_end = (cnt_q == period_q - PERIOD_W'(1));

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        if (load) begin
            // Periods below two cycles leave no room for a mid-bit sample, so clamp them.
            period_d = (period_in < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period_in;
            cnt_d    = '0;
            idx_d    = IDX_W'(FRAME_BITS - 1);
        end else if (en) begin
            if (at_end) begin
                cnt_d = '0;
                idx_d = idx_q - IDX_W'(1);
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
        end
    end

    assign sync_stb   = en && (cnt_q == '0);
    assign sample_stb = en && (cnt_q == (period_q >> 1));
    assign wrap_stb   = en && at_end;
    assign last_bit   = (idx_q == '0);

endmodule

// File: rtl/dspace_com_master.sv
// Master end of the FPGA-to-FPGA link: frames a 12-bit full-duplex exchange, MSB first,
// driving start/sync strobes and serial data while shifting in the slave's reply.
module dspace_com_master
    import dspace_com_master_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                Mstart,
    input  logic [PERIOD_W-1:0] bit_rate_fpga,
    input  logic [WORD_W-1:0]   tx_w1,
    input  logic [WORD_W-1:0]   tx_w2,
    input  logic [WORD_W-1:0]   tx_w3,
    input  logic                fpga_in,
    output logic                fpga_out,
    output logic                Sstart,
    output logic                sync_master,
    output logic [WORD_W-1:0]   rx_w1,
    output logic [WORD_W-1:0]   rx_w2,
    output logic [WORD_W-1:0]   rx_w3,
    output logic                busy,
    output logic                done
);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   tx_sr_q, tx_sr_d;
    logic [FRAME_BITS-1:0]   rx_sr_q, rx_sr_d;
    logic [FRAME_BITS-1:0]   rx_q, rx_d;
    logic                    fpga_out_q, fpga_out_d;
    logic                    tmr_load;
    logic                    tmr_en;
    logic                    sync_stb;
    logic                    sample_stb;
    logic                    wrap_stb;
    logic                    last_bit;

    assign tmr_en = (state_q == SHIFT);

    dspace_com_master_fpga_bit_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .en         (tmr_en),
        .period_in  (bit_rate_fpga),
        .sync_stb   (sync_stb),
        .sample_stb (sample_stb),
        .wrap_stb   (wrap_stb),
        .last_bit   (last_bit)
    );

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_d       = rx_q;
        fpga_out_d = fpga_out_q;
        tmr_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Mstart) begin
                    tmr_load = 1'b1;
                    tx_sr_d  = {tx_w1, tx_w2, tx_w3};
                    state_d  = START;
                end
            end
            START: begin
                // Present the first bit so it is on the wire for the whole first bit period.
                fpga_out_d = tx_sr_q[FRAME_BITS-1];
                tx_sr_d    = tx_sr_q << 1;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (sample_stb) begin
                    rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], fpga_in};
                end
                // With P=2 the last sample and the end of the frame share a cycle, hence rx_sr_d.
                if (wrap_stb) begin
                    if (last_bit) begin
                        fpga_out_d = 1'b0;
                        rx_d       = rx_sr_d;
                        state_d    = DONE;
                    end else begin
                        fpga_out_d = tx_sr_q[FRAME_BITS-1];
                        tx_sr_d    = tx_sr_q << 1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_q       <= '0;
            fpga_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_q       <= rx_d;
            fpga_out_q <= fpga_out_d;
        end
    end

    assign fpga_out    = fpga_out_q;
    assign Sstart      = (state_q == START);
    assign sync_master = sync_stb;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign rx_w1       = rx_q[3*WORD_W-1:2*WORD_W];
    assign rx_w2       = rx_q[2*WORD_W-1:WORD_W];
    assign rx_w3       = rx_q[WORD_W-1:0];

endmodule

// File: tb/tb_dspace_com_master.sv
// Directed bench for dspace_com_master: expected replies and done cycles are queued at
// accept time and checked by a monitor when done pulses.
module tb_dspace_com_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       Mstart;
    logic [7:0] bit_rate_fpga;
    logic [3:0] tx_w1, tx_w2, tx_w3;
    logic       fpga_in;
    logic       fpga_out, Sstart, sync_master, busy, done;
    logic [3:0] rx_w1, rx_w2, rx_w3;

    dspace_com_master dut (
        .clk           (clk),
        .rst           (rst),
        .Mstart        (Mstart),
        .bit_rate_fpga (bit_rate_fpga),
        .tx_w1         (tx_w1),
        .tx_w2         (tx_w2),
        .tx_w3         (tx_w3),
        .fpga_in       (fpga_in),
        .fpga_out      (fpga_out),
        .Sstart        (Sstart),
        .sync_master   (sync_master),
        .rx_w1         (rx_w1),
        .rx_w2         (rx_w2),
        .rx_w3         (rx_w3),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rx;
        int          accept;
        int          done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          assert_cnt = 0;
    int          fail_cnt = 0;
    int          exp_gap = 2;
    int          frame_syncs = 0;
    int          last_sync = 0;
    int          sstart_cyc = 0;
    int          sstart_total = 0;
    logic        lb_q = 1'b0;
    logic        use_pat = 1'b0;
    logic [11:0] pat_reg = 12'h000;
    logic        pat_bit = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) lb_q <= fpga_out;
    assign fpga_in = use_pat ? pat_bit : lb_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: Sstart/sync timing, and scoreboard pop on done.
    always @(negedge clk) begin
        if (rst) frame_syncs = 0;
        if (Sstart) begin
            sstart_total++;
            sstart_cyc  = cyc;
            frame_syncs = 0;
            if (sb_q.size() != 0) chk("sstart_cycle", cyc - sb_q[0].accept, 1);
        end
        if (sync_master) begin
            if (frame_syncs == 0) chk("first_sync", cyc - sstart_cyc, 1);
            else                  chk("sync_gap", cyc - last_sync, exp_gap);
            last_sync = cyc;
            frame_syncs++;
            if (frame_syncs <= 12) pat_bit = pat_reg[12 - frame_syncs];
        end
        if (done) begin
            chk("sync_count", frame_syncs, 12);
            chk("busy_at_done", busy, 1);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_cycle", cyc - e.accept, e.done_cyc - e.accept);
                chk("rx_w1", rx_w1, e.rx[11:8]);
                chk("rx_w2", rx_w2, e.rx[7:4]);
                chk("rx_w3", rx_w3, e.rx[3:0]);
            end
        end
    end

    // Called at a negedge with the DUT idle; accept happens at the following posedge.
    task automatic start_frame(input logic [7:0] p, input logic [11:0] tx,
                               input logic [11:0] exp_rx, input bit expect_done,
                               output int c0);
        int   peff;
        exp_t e;
        peff          = (p < 2) ? 2 : int'(p);
        exp_gap       = peff;
        tx_w1         = tx[11:8];
        tx_w2         = tx[7:4];
        tx_w3         = tx[3:0];
        bit_rate_fpga = p;
        Mstart        = 1'b1;
        c0            = cyc;
        if (expect_done) begin
            e.rx       = exp_rx;
            e.accept   = c0;
            e.done_cyc = c0 + 2 + 12 * peff;
            sb_q.push_back(e);
        end
        @(negedge clk);
        Mstart = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int   c0;
        int   s0;
        exp_t e;
        rst = 1'b1; Mstart = 1'b0; bit_rate_fpga = 8'd8;
        tx_w1 = 4'h0; tx_w2 = 4'h0; tx_w3 = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_fpga_out", fpga_out, 0);
        chk("rst_sstart", Sstart, 0);
        chk("rst_sync", sync_master, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", {rx_w1, rx_w2, rx_w3}, 12'h000);
        rst = 1'b0;
        @(negedge clk);

        // Loopback, P=8.
        start_frame(8'd8, 12'h57D, 12'h57D, 1'b1, c0);
        chk("busy_after_accept", busy, 1);
        drain(200);
        chk("busy_after_done", busy, 0);

        // Slave drives a fixed pattern aligned to sync.
        use_pat = 1'b1; pat_reg = 12'hA3C;
        start_frame(8'd8, 12'h000, 12'hA3C, 1'b1, c0);
        drain(200);
        use_pat = 1'b0;

        // Short periods clamp to 2.
        start_frame(8'd0, 12'h9E1, 12'h9E1, 1'b1, c0);
        drain(60);
        start_frame(8'd1, 12'h248, 12'h248, 1'b1, c0);
        drain(60);

        // Mstart held high: three back-to-back frames, 51 cycles apart.
        s0 = sstart_total;
        tx_w1 = 4'hB; tx_w2 = 4'h6; tx_w3 = 4'hF; bit_rate_fpga = 8'd4; exp_gap = 4;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            e.rx = 12'hB6F; e.accept = c0 + 51 * i; e.done_cyc = c0 + 51 * i + 50;
            sb_q.push_back(e);
        end
        Mstart = 1'b1;
        wait_until(c0 + 152);
        Mstart = 1'b0;
        drain(20);
        repeat (5) @(negedge clk);
        chk("b2b_sstart_count", sstart_total - s0, 3);
        chk("b2b_idle", busy, 0);

        // Reset at cycle 40 of a P=8 frame.
        start_frame(8'd8, 12'h123, 12'h000, 1'b0, c0);
        wait_until(c0 + 40);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_fpga_out", fpga_out, 0);
        chk("abort_sstart", Sstart, 0);
        chk("abort_sync", sync_master, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rx", {rx_w1, rx_w2, rx_w3}, 12'h000);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        chk("abort_rx_held", {rx_w1, rx_w2, rx_w3}, 12'h000);
        start_frame(8'd8, 12'hC5A, 12'hC5A, 1'b1, c0);
        drain(200);

        // Inputs change mid-frame; latched copies must be used.
        start_frame(8'd8, 12'h123, 12'h123, 1'b1, c0);
        wait_until(c0 + 20);
        tx_w1 = 4'hF; bit_rate_fpga = 8'd3;
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
